// File: rtl/servo_avalon_if.sv
// Avalon-MM slave bus for servo_avalon: one write register (pulse length)
// and one read register (measured width plus valid flag), no address bus.
interface servo_avalon_if #(
  parameter int WIDTH = 32
);
  logic             read;
  logic             write;
  logic             chipselect;
  logic [WIDTH-1:0] readdata;
  logic [WIDTH-1:0] writedata;

  modport master (
    output read,
    output write,
    output chipselect,
    output writedata,
    input  readdata
  );

  modport slave (
    input  read,
    input  write,
    input  chipselect,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/servo_avalon.sv
// Servo / range-sensor pulse engine: fires a pulse of a programmed length on
// pwm_out and measures the high width of the returning pwm_response pulse.
module servo_avalon #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  servo_avalon_if.slave  bus,
  input  logic           pwm_response,
  output logic           pwm_out
);

  localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);
  localparam logic [WIDTH-1:0]  MEAS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   pulse_cnt;
  logic [WIDTH-1:0]   meas_cnt;
  logic [WIDTH-1:0]   meas_next;
  logic [WIDTH-2:0]   result;
  logic [WIDTH-2:0]   result_next;
  logic               valid;
  logic               valid_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILL_W-1:0]  fill_cnt;
  logic               armed;
  logic               resp_s;
  logic               resp_prev;
  logic               resp_rise;
  logic               resp_fall;
  logic               wr_en;
  logic               rd_en;

  assign wr_en = bus.chipselect & bus.write;
  assign rd_en = bus.chipselect & bus.read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
    end else if (wr_en) begin
      pulse_cnt <= bus.writedata;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - WIDTH'(1);
    end
  end

  assign pwm_out = (pulse_cnt != '0);

  // The chain only holds real samples once SYNC_STAGES edges have passed since
  // reset; arming waits for a genuine low so a response already high at
  // release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      resp_prev <= 1'b0;
      fill_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_STAGES'(pwm_response);
      resp_prev <= resp_s;
      if (fill_cnt != FILL_DONE) begin
        fill_cnt <= fill_cnt + FILL_W'(1);
      end
      if (fill_cnt == FILL_DONE && !resp_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign resp_s    = sync_q[SYNC_STAGES-1];
  assign resp_rise = armed & resp_s & ~resp_prev;
  assign resp_fall = ~resp_s & resp_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      meas_cnt <= '0;
      result   <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_next;
      meas_cnt <= meas_next;
      result   <= result_next;
      valid    <= valid_next;
    end
  end

  // A completing measurement overrides a same-edge write clearing valid.
  always_comb begin
    state_next  = state;
    meas_next   = meas_cnt;
    result_next = result;
    valid_next  = valid;
    if (wr_en) begin
      valid_next = 1'b0;
    end
    case (state)
      IDLE: begin
        if (resp_rise) begin
          meas_next  = WIDTH'(1);
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (resp_fall) begin
          result_next = meas_cnt[WIDTH-2:0];
          valid_next  = 1'b1;
          state_next  = IDLE;
        end else if (resp_s && meas_cnt != MEAS_MAX) begin
          meas_next = meas_cnt + WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.readdata = '0;
    if (rd_en) begin
      bus.readdata = {valid, result};
    end
  end

endmodule

// File: tb/tb_servo_avalon.sv
// Self-checking bench for servo_avalon: directed steps plus randomized traffic,
// compared against a deadline / run-length reference model.
module tb_servo_avalon;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic pwm_response;
  logic pwm_out;

  servo_avalon_if #(.WIDTH(WIDTH)) bus ();

  servo_avalon #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .pwm_response (pwm_response),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  // Reference model: pwm_out is high until a deadline set by the last write;
  // each completed high run of sampled responses lands in the read register
  // SYNC edges after the first low sample.
  longint      cyc;
  longint      pulse_end;
  int          since_rst;
  int          run_len;
  bit          run_ignored;
  bit          exp_valid;
  logic [30:0] exp_result;
  longint      done_at[$];
  int          done_len[$];
  int          vectors;
  int          miscompares;

  task automatic model_reset();
    pulse_end   = cyc;
    since_rst   = 0;
    run_len     = 0;
    run_ignored = 0;
    exp_valid   = 0;
    exp_result  = '0;
    done_at.delete();
    done_len.delete();
  endtask

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
             tag, observed, expected, cyc);
    end
  endtask

  task automatic check_output(input string tag);
    logic        exp_pwm;
    logic [31:0] exp_rd;
    exp_pwm = (cyc < pulse_end);
    exp_rd  = (bus.chipselect && bus.read) ? {exp_valid, exp_result} : 32'h0;
    vectors++;
    assert (pwm_out === exp_pwm) else begin
      miscompares++;
      $error("[TB] FAIL %s pwm_out: got %b expected %b at cycle %0d",
             tag, pwm_out, exp_pwm, cyc);
    end
    vectors++;
    assert (bus.readdata === exp_rd) else begin
      miscompares++;
      $error("[TB] FAIL %s readdata: got 0x%08h expected 0x%08h at cycle %0d",
             tag, bus.readdata, exp_rd, cyc);
    end
  endtask

  task automatic tick(input string tag);
    bit          s;
    bit          w;
    logic [31:0] wd;
    s  = pwm_response;
    w  = bus.chipselect && bus.write;
    wd = bus.writedata;
    @(posedge clk);
    cyc++;
    if (reset_n) begin
      since_rst++;
      if (w) begin
        pulse_end = cyc + longint'(wd);
        exp_valid = 0;
      end
      if (s) begin
        if (run_len == 0 && since_rst == 1) run_ignored = 1;
        run_len++;
      end else if (run_len > 0) begin
        if (!run_ignored) begin
          done_at.push_back(cyc + SYNC);
          done_len.push_back(run_len);
        end
        run_len     = 0;
        run_ignored = 0;
      end
      if (done_at.size() > 0 && done_at[0] == cyc) begin
        exp_result = 31'(done_len[0]);
        exp_valid  = 1;
        void'(done_at.pop_front());
        void'(done_len.pop_front());
      end
    end else begin
      pulse_end = cyc;
    end
    #1;
    check_output(tag);
  endtask

  task automatic apply_stimulus(input bit cs, input bit wr, input bit rd,
                                input logic [31:0] wd);
    bus.chipselect = cs;
    bus.write      = wr;
    bus.read       = rd;
    bus.writedata  = wd;
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_value("async_reset_pwm", {31'h0, pwm_out}, 32'h0);
    check_value("async_reset_rd", bus.readdata, 32'h0);
    model_reset();
  endtask

  initial begin
    int resp_left;
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset_n      = 1'b0;
    pwm_response = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    model_reset();
    for (int i = 0; i < 3; i++) tick("reset_hold");
    reset_n = 1'b1;
    tick("reset_release");
    check_value("reset_readdata", bus.readdata, 32'h0);

    $display("[TB] async reset mid-pulse");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'd20);
    tick("pulse20_write");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) tick("pulse20_run");
    async_reset();
    for (int i = 0; i < 2; i++) tick("reset_hold");
    reset_n = 1'b1;
    tick("reset_release");

    $display("[TB] single-cycle write of 5");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'd5);
    tick("pulse5_write");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) tick("pulse5_run");

    $display("[TB] held write of 3 for 5 cycles, then write 0 mid-pulse");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'd3);
    for (int i = 0; i < 5; i++) tick("held3_write");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 9; i++) tick("held3_run");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'd20);
    tick("abort_load");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) tick("abort_run");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'd0);
    tick("abort_zero");
    check_value("abort_pwm_low", {31'h0, pwm_out}, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 2; i++) tick("abort_idle");

    $display("[TB] 40-cycle response measurement");
    pwm_response = 1'b1;
    for (int i = 0; i < 40; i++) tick("meas40_high");
    pwm_response = 1'b0;
    for (int i = 0; i < SYNC; i++) tick("meas40_sync");
    check_value("meas40_not_yet", bus.readdata, 32'h0);
    tick("meas40_done");
    check_value("meas40_result", bus.readdata, 32'h8000_0028);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'd1);
    tick("meas40_clear");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    check_value("meas40_valid_cleared", {31'h0, bus.readdata[31]}, 32'h0);
    for (int i = 0; i < 2; i++) tick("meas40_idle");

    $display("[TB] response high through reset release");
    pwm_response = 1'b1;
    async_reset();
    for (int i = 0; i < 2; i++) tick("glitch_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("glitch_high");
    pwm_response = 1'b0;
    for (int i = 0; i < 8; i++) tick("glitch_low");
    check_value("glitch_ignored", bus.readdata, 32'h0);
    pwm_response = 1'b1;
    for (int i = 0; i < 10; i++) tick("meas10_high");
    pwm_response = 1'b0;
    for (int i = 0; i < SYNC + 1; i++) tick("meas10_sync");
    check_value("meas10_result", bus.readdata, 32'h8000_000A);

    $display("[TB] chipselect gating");
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'd9);
    for (int i = 0; i < 3; i++) tick("cs_off");
    check_value("cs_off_pwm", {31'h0, pwm_out}, 32'h0);
    check_value("cs_off_rd", bus.readdata, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    tick("cs_on");
    check_value("cs_on_rd", bus.readdata, 32'h8000_000A);

    $display("[TB] randomized traffic");
    resp_left = 3;
    for (int i = 0; i < 600; i++) begin
      if (resp_left == 0) begin
        pwm_response = ~pwm_response;
        resp_left = pwm_response ? int'($urandom_range(1, 25))
                                 : int'($urandom_range(2, 8));
      end
      resp_left--;
      apply_stimulus($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) != 0, 32'($urandom_range(0, 12)));
      tick("random");
    end
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);

    $display("[TB] async reset mid-measurement");
    pwm_response = 1'b0;
    for (int i = 0; i < 4; i++) tick("mid_low");
    pwm_response = 1'b1;
    for (int i = 0; i < 6; i++) tick("mid_high");
    pwm_response = 1'b0;
    async_reset();
    for (int i = 0; i < 2; i++) tick("mid_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick("mid_after");
    check_value("mid_discarded", bus.readdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
